reorder_buffer_tagged: RTL and testbench

REORDER_BUFFER_TAGGED -- requirements
Module: reorder_buffer_tagged

---
 rtl/reorder_buffer_tagged.sv | 111 +++++++++++
 tb/tb_reorder_buffer_tagged.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer_tagged.sv
// Tagged reorder buffer: issues tags in order, accepts out-of-order completions, retires in tag order.
// Completion-to-output latency 1 cycle; head holds while ready_in=0 and alloc_gnt drops when full.
module reorder_buffer_tagged #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 8,
  localparam int ID_W   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alloc_req,
  output logic              alloc_gnt,
  output logic [ID_W-1:0]   alloc_id,
  input  logic              valid_in,
  input  logic [ID_W-1:0]   id_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              ready_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_out,
  output logic [ID_W-1:0]   id_out,
  input  logic              ready_in,
  input  logic              flush,
  output logic [ID_W:0]     count,
  output logic              err_dup,
  output logic              err_unalloc
);

  localparam logic [ID_W:0] DEPTH_C = (ID_W+1)'(DEPTH);

  logic [ID_W:0]       head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]    alloc_q, alloc_d, done_q, done_d;
  logic [DATA_W-1:0]   data_q [DEPTH];
  logic [DATA_W-1:0]   data_d [DEPTH];
  logic                err_dup_q, err_dup_d, err_unalloc_q, err_unalloc_d;
  logic [ID_W-1:0]     head_idx, tail_idx;
  logic                alloc_fire, cpl_fire, retire_fire;

  assign head_idx    = head_q[ID_W-1:0];
  assign tail_idx    = tail_q[ID_W-1:0];
  assign count       = tail_q - head_q;
  assign alloc_gnt   = (count < DEPTH_C) && !flush;
  assign alloc_id    = tail_idx;
  assign ready_out   = !flush;
  assign valid_out   = alloc_q[head_idx] && done_q[head_idx];
  assign data_out    = data_q[head_idx];
  assign id_out      = head_idx;
  assign err_dup     = err_dup_q;
  assign err_unalloc = err_unalloc_q;

  assign alloc_fire  = alloc_req && alloc_gnt;
  assign cpl_fire    = valid_in && ready_out;
  assign retire_fire = valid_out && ready_in;

  // Completion legality is judged on pre-edge state, so a tag allocated this cycle is still unallocated.
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    alloc_d       = alloc_q;
    done_d        = done_q;
    data_d        = data_q;
    err_dup_d     = 1'b0;
    err_unalloc_d = 1'b0;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      alloc_d = '0;
      done_d  = '0;
    end else begin
      if (cpl_fire) begin
        if (!alloc_q[id_in]) begin
          err_unalloc_d = 1'b1;
        end else if (done_q[id_in]) begin
          err_dup_d = 1'b1;
        end else begin
          data_d[id_in] = data_in;
          done_d[id_in] = 1'b1;
        end
      end
      if (retire_fire) begin
        alloc_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + 1'b1;
      end
      if (alloc_fire) begin
        alloc_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        tail_d            = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      alloc_q       <= '0;
      done_q        <= '0;
      err_dup_q     <= 1'b0;
      err_unalloc_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      alloc_q       <= alloc_d;
      done_q        <= done_d;
      err_dup_q     <= err_dup_d;
      err_unalloc_q <= err_unalloc_d;
      data_q        <= data_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer_tagged.sv
// Bench for reorder_buffer_tagged: directed scenarios followed by random traffic, checked by a tag-queue reference model.
module tb_reorder_buffer_tagged;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ID_W   = 3;

  logic              clk, rst;
  logic              alloc_req, alloc_gnt;
  logic [ID_W-1:0]   alloc_id;
  logic              valid_in, ready_out;
  logic [ID_W-1:0]   id_in;
  logic [DATA_W-1:0] data_in;
  logic              valid_out, ready_in;
  logic [DATA_W-1:0] data_out;
  logic [ID_W-1:0]   id_out;
  logic              flush;
  logic [ID_W:0]     count;
  logic              err_dup, err_unalloc;

  reorder_buffer_tagged #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_id(alloc_id),
    .valid_in(valid_in), .id_in(id_in), .data_in(data_in), .ready_out(ready_out),
    .valid_out(valid_out), .data_out(data_out), .id_out(id_out), .ready_in(ready_in),
    .flush(flush), .count(count), .err_dup(err_dup), .err_unalloc(err_unalloc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: outstanding tags in issue order, plus per-tag completion state and data.
  int          q_tags[$];
  bit          m_alloc [DEPTH];
  bit          m_done  [DEPTH];
  logic [7:0]  m_data  [DEPTH];
  int          next_tag;
  bit          e_dup, e_unal;
  int          total, bad, n_ret;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q_tags.delete();
    for (int i = 0; i < DEPTH; i++) begin
      m_alloc[i] = 1'b0;
      m_done[i]  = 1'b0;
      m_data[i]  = 8'h00;
    end
    next_tag = 0;
    e_dup    = 1'b0;
    e_unal   = 1'b0;
  endtask

  // Monitor: compares at the falling edge, then advances the model by the rising edge that follows.
  always @(negedge clk) begin
    int h, exp_tag, cid;
    bit gnt, vout;
    if (!rst) model_reset();
    h    = (q_tags.size() > 0) ? q_tags[0] : next_tag;
    gnt  = (q_tags.size() < DEPTH) && !flush;
    vout = (q_tags.size() > 0) && m_done[h];
    chk("alloc_gnt",   32'(alloc_gnt),   32'(gnt));
    chk("alloc_id",    32'(alloc_id),    32'(next_tag));
    chk("ready_out",   32'(ready_out),   32'(!flush));
    chk("valid_out",   32'(valid_out),   32'(vout));
    chk("id_out",      32'(id_out),      32'(h));
    chk("data_out",    32'(data_out),    32'(m_data[h]));
    chk("count",       32'(count),       32'(q_tags.size()));
    chk("err_dup",     32'(err_dup),     32'(e_dup));
    chk("err_unalloc", 32'(err_unalloc), 32'(e_unal));
    if (rst) begin
      e_dup  = 1'b0;
      e_unal = 1'b0;
      if (flush) begin
        q_tags.delete();
        for (int i = 0; i < DEPTH; i++) begin
          m_alloc[i] = 1'b0;
          m_done[i]  = 1'b0;
        end
        next_tag = 0;
      end else begin
        if (valid_in) begin
          cid = int'(id_in);
          if (!m_alloc[cid]) e_unal = 1'b1;
          else if (m_done[cid]) e_dup = 1'b1;
          else begin
            m_done[cid] = 1'b1;
            m_data[cid] = data_in;
          end
        end
        if (vout && ready_in) begin
          exp_tag = q_tags.pop_front();
          chk("retire_id",   32'(id_out),   32'(exp_tag));
          chk("retire_data", 32'(data_out), 32'(m_data[exp_tag]));
          m_alloc[exp_tag] = 1'b0;
          m_done[exp_tag]  = 1'b0;
          n_ret++;
        end
        if (alloc_req && gnt) begin
          m_alloc[next_tag] = 1'b1;
          m_done[next_tag]  = 1'b0;
          q_tags.push_back(next_tag);
          next_tag = (next_tag + 1) % DEPTH;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic alloc_n(input int n);
    alloc_req = 1'b1;
    repeat (n) cyc();
    alloc_req = 1'b0;
  endtask

  task automatic complete(input int id, input logic [7:0] d);
    valid_in = 1'b1;
    id_in    = ID_W'(id);
    data_in  = d;
    cyc();
    valid_in = 1'b0;
  endtask

  initial begin
    int base, t;
    rst = 1'b0; alloc_req = 1'b0; valid_in = 1'b0; id_in = '0; data_in = '0;
    ready_in = 1'b1; flush = 1'b0;
    total = 0; bad = 0; n_ret = 0;
    repeat (3) cyc();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_gnt",   32'(alloc_gnt), 32'd1);
    rst = 1'b1;

    // Fill, attempt one extra allocation while full, then complete in order.
    base = n_ret;
    alloc_n(8);
    alloc_n(1);
    for (int i = 0; i < 8; i++) complete(i, 8'(i * 16 + 5));
    repeat (3) cyc();
    chk("inorder_retires", 32'(n_ret - base), 32'd8);

    // Reverse-order completion: nothing leaves until tag 0 lands.
    base = n_ret;
    alloc_n(8);
    for (int i = 7; i >= 0; i--) complete(i, 8'(8'hA0 + i));
    repeat (10) cyc();
    chk("reverse_retires", 32'(n_ret - base), 32'd8);

    // Duplicate completion on tag 1 keeps the first data.
    base = n_ret;
    alloc_n(3);
    complete(1, 8'h11);
    complete(1, 8'h22);
    complete(0, 8'h33);
    complete(2, 8'h44);
    repeat (4) cyc();
    chk("dup_retires", 32'(n_ret - base), 32'd3);

    // Completion to an unallocated tag.
    base = n_ret;
    complete(3, 8'h5A);
    repeat (3) cyc();
    chk("unalloc_retires", 32'(n_ret - base), 32'd0);
    chk("unalloc_count",   32'(count), 32'd0);

    // Stall with head done, then 12 allocations interleaved with retires.
    flush = 1'b1; cyc(); flush = 1'b0;
    base = n_ret;
    ready_in = 1'b0;
    alloc_n(1);
    complete(0, 8'h77);
    repeat (5) cyc();
    ready_in = 1'b1;
    for (int i = 1; i < 12; i++) begin
      alloc_n(1);
      complete(i % DEPTH, 8'(8'hC0 + i));
    end
    repeat (3) cyc();
    chk("interleave_retires", 32'(n_ret - base), 32'd12);

    // Flush with 5 allocated, competing alloc and completion in the same cycle.
    alloc_n(5);
    complete(4, 8'h99);
    alloc_req = 1'b1; valid_in = 1'b1; id_in = 3'd5; flush = 1'b1;
    cyc();
    alloc_req = 1'b0; valid_in = 1'b0; flush = 1'b0;
    chk("flush_count",   32'(count),     32'd0);
    chk("flush_valid",   32'(valid_out), 32'd0);
    chk("flush_allocid", 32'(alloc_id),  32'd0);
    alloc_n(4);
    complete(1, 8'h66);
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    chk("mrst_gnt",      32'(alloc_gnt), 32'd1);
    chk("mrst_allocid",  32'(alloc_id),  32'd0);
    chk("mrst_ready",    32'(ready_out), 32'd1);
    chk("mrst_valid",    32'(valid_out), 32'd0);
    chk("mrst_data",     32'(data_out),  32'd0);
    chk("mrst_id",       32'(id_out),    32'd0);
    chk("mrst_count",    32'(count),     32'd0);

    // Random traffic.
    repeat (3000) begin
      alloc_req = ($urandom_range(0, 99) < 50);
      valid_in  = ($urandom_range(0, 99) < 60);
      t = $urandom_range(0, DEPTH - 1);
      for (int k = 0; k < 4 && !(m_alloc[t] && !m_done[t]); k++) t = $urandom_range(0, DEPTH - 1);
      if ($urandom_range(0, 9) == 0) t = $urandom_range(0, DEPTH - 1);
      id_in    = ID_W'(t);
      data_in  = 8'($urandom);
      ready_in = ($urandom_range(0, 99) < 75);
      flush    = ($urandom_range(0, 99) < 2);
      rst      = ($urandom_range(0, 199) != 0);
      cyc();
    end
    rst = 1'b1; alloc_req = 1'b0; valid_in = 1'b0; flush = 1'b0; ready_in = 1'b1;
    repeat (3) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
